// File: rtl/riscv_pkg.sv
// Shared front-end definitions: fetch FSM states and instruction/PC constants.
package riscv_pkg;

    typedef enum logic [1:0] {
        FS_RESET = 2'd0,
        FS_REQ   = 2'd1,
        FS_WAIT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection: redirect target, sequential advance, or hold.
module fetch_pc_next
    import riscv_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        advance,
    output logic [31:0] pc_next
);

    // Redirect outranks the sequential step; targets are forced word-aligned.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = redirect_pc & 32'hFFFF_FFFC;
        end else if (advance) begin
            pc_next = pc + PC_INC;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem
// request at a time and holds the fetched instruction in the IF/ID slot.
module fetch_ctrl
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_instr_o,
    output logic [31:0] if_pc_o
);

    fetch_state_t state, state_next;
    logic [31:0]  pc, pc_next;
    logic         kill, kill_next;
    logic         out_valid;
    logic [31:0]  out_instr;
    logic [31:0]  out_pc;

    logic         req;
    logic         granted;
    logic         resp;
    logic         accept;

    assign granted = req && imem_gnt_i;
    assign resp    = (state == FS_WAIT) && imem_rvalid_i;
    assign accept  = resp && !kill;

    fetch_pc_next u_pc_next (
        .pc          (pc),
        .redirect    (redirect_i),
        .redirect_pc (redirect_pc_i),
        .advance     (accept),
        .pc_next     (pc_next)
    );

    // State, PC and kill-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FS_RESET;
            pc    <= RESET_PC;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            kill  <= kill_next;
        end
    end

    // Next-state and kill tracking; a redirect poisons any in-flight response.
    always_comb begin
        state_next = state;
        kill_next  = kill;
        case (state)
            FS_RESET: state_next = FS_REQ;
            FS_REQ: begin
                if (granted) begin
                    state_next = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_rvalid_i) begin
                    state_next = FS_REQ;
                    kill_next  = 1'b0;
                end
            end
            default: state_next = FS_RESET;
        endcase
        if (redirect_i && (granted || ((state == FS_WAIT) && !imem_rvalid_i))) begin
            kill_next = 1'b1;
        end
    end

    // Request only when the response is guaranteed a free slot to land in.
    always_comb begin
        req = 1'b0;
        if (state == FS_REQ) begin
            req = !out_valid || !stall_i;
        end
    end

    // Output slot: redirect flushes, a fresh response loads, otherwise ID drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            out_pc    <= 32'h0000_0000;
        end else if (redirect_i) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= imem_rdata_i;
            out_pc    <= pc;
        end else if (out_valid && !stall_i) begin
            out_valid <= 1'b0;
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc;
    assign if_valid_o  = out_valid;
    assign if_instr_o  = out_instr;
    assign if_pc_o     = out_pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations, and a second instance
// with a wrapping reset PC.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Memory content is a fixed function of address so a wrong fetch address shows up.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return {a[21:2], 12'h013};
        endcase
    endfunction

    // ---------------- DUT 1 (RESET_PC = 0) ----------------
    logic        rst, stall, redirect;
    logic [31:0] redirect_pc;
    logic        req, gnt, rvalid;
    logic [31:0] addr, rdata;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        gnt_en;
    int          lat;

    assign gnt = req & gnt_en;

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_gnt_i    (gnt),
        .imem_rvalid_i (rvalid),
        .imem_rdata_i  (rdata),
        .if_valid_o    (if_valid),
        .if_instr_o    (if_instr),
        .if_pc_o       (if_pc)
    );

    // Memory with per-request latency (captured at grant time).
    logic        pend;
    logic [31:0] pend_addr;
    int          cnt;
    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0; pend_addr <= '0; cnt <= 0; rvalid <= 1'b0; rdata <= '0;
        end else begin
            rvalid <= 1'b0;
            if (req && gnt) begin
                if (lat <= 1) begin
                    rvalid <= 1'b1;
                    rdata  <= mem_word(addr);
                end else begin
                    pend <= 1'b1; pend_addr <= addr; cnt <= lat - 1;
                end
            end else if (pend) begin
                if (cnt <= 1) begin
                    rvalid <= 1'b1;
                    rdata  <= mem_word(pend_addr);
                    pend   <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    // Reference model: next fetch address, whether a fetch is outstanding,
    // whether that fetch is stale, and the presented slot.
    logic        m_ready, m_busy, m_kill, m_v;
    logic [31:0] m_pc, m_i, m_spc;
    logic        exp_req, m_granted, m_resp, m_consume;

    assign exp_req   = m_ready && !m_busy && (!m_v || !stall);
    assign m_granted = exp_req && gnt_en;
    assign m_resp    = m_busy && rvalid;
    assign m_consume = m_v && !stall;

    always @(posedge clk) begin
        if (rst) begin
            m_ready <= 1'b0; m_busy <= 1'b0; m_kill <= 1'b0; m_v <= 1'b0;
            m_pc <= 32'h0; m_i <= 32'h0000_0013; m_spc <= 32'h0;
        end else begin
            m_ready <= 1'b1;
            if (redirect) begin
                m_pc <= redirect_pc & 32'hFFFF_FFFC;
                m_v  <= 1'b0;
                if (m_granted || (m_busy && !m_resp)) begin
                    m_busy <= 1'b1; m_kill <= 1'b1;
                end else if (m_resp) begin
                    m_busy <= 1'b0; m_kill <= 1'b0;
                end
            end else if (m_resp) begin
                m_busy <= 1'b0;
                if (m_kill) begin
                    m_kill <= 1'b0;
                    if (m_consume) m_v <= 1'b0;
                end else begin
                    m_v <= 1'b1; m_i <= mem_word(m_pc); m_spc <= m_pc; m_pc <= m_pc + 32'd4;
                end
            end else begin
                if (m_granted) m_busy <= 1'b1;
                if (m_consume) m_v <= 1'b0;
            end
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req",   {31'b0, req},      {31'b0, exp_req});
            chk("m_addr",  addr,              m_pc);
            chk("m_valid", {31'b0, if_valid}, {31'b0, m_v});
            chk("m_instr", if_instr,          m_i);
            chk("m_pc",    if_pc,             m_spc);
        end
    end

    // ---------------- DUT 2 (RESET_PC = 0xFFFF_FFFC) ----------------
    logic        rst2, stall2, redirect2;
    logic [31:0] redirect_pc2;
    logic        req2, gnt2, rvalid2;
    logic [31:0] addr2, rdata2;
    logic        valid2;
    logic [31:0] instr2, pc2;

    assign gnt2 = req2;

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (
        .clk           (clk),
        .rst           (rst2),
        .stall_i       (stall2),
        .redirect_i    (redirect2),
        .redirect_pc_i (redirect_pc2),
        .imem_req_o    (req2),
        .imem_addr_o   (addr2),
        .imem_gnt_i    (gnt2),
        .imem_rvalid_i (rvalid2),
        .imem_rdata_i  (rdata2),
        .if_valid_o    (valid2),
        .if_instr_o    (instr2),
        .if_pc_o       (pc2)
    );

    // Single-cycle-latency responder for DUT 2.
    always @(posedge clk) begin
        if (rst2) begin
            rvalid2 <= 1'b0; rdata2 <= '0;
        end else begin
            rvalid2 <= req2 && gnt2;
            rdata2  <= mem_word(addr2);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        gnt_en = 1'b1; lat = 1;
        rst2 = 1'b1; stall2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = '0;

        repeat (3) step();
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_req",   {31'b0, req},      32'h0);
        chk("rst_addr",  addr,              32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_instr", if_instr,          32'h0000_0013);
        chk("rst_pc",    if_pc,             32'h0);

        // Basic fetch with 1-cycle memory.
        step(); rst = 1'b0;
        n = 0;
        @(negedge clk);
        while (!if_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_cycle", n, 3);
        chk("first_pc",    if_pc,    32'h0);
        chk("first_instr", if_instr, 32'h0050_0093);
        chk("second_req",  {31'b0, req}, 32'h1);
        chk("second_addr", addr,     32'h4);

        // Stall with valid slot at pc 0x4.
        step(); step(); stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, if_valid}, 32'h1);
            chk("stall_pc",    if_pc,    32'h4);
            chk("stall_instr", if_instr, 32'h00A0_0113);
            chk("stall_req",   {31'b0, req}, 32'h0);
            step();
        end
        stall = 1'b0; lat = 3;
        @(negedge clk);
        chk("release_req",  {31'b0, req}, 32'h1);
        chk("release_addr", addr, 32'h8);

        // Redirect while waiting on 0x8; its response must be dropped.
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step(); redirect = 1'b0; lat = 1;
        n = 0;
        @(negedge clk);
        while (!req && n < 10) begin
            chk("kill_no_valid", {31'b0, if_valid}, 32'h0);
            @(negedge clk);
            n++;
        end
        chk("redir_req",  {31'b0, req}, 32'h1);
        chk("redir_addr", addr, 32'h100);
        n = 0;
        while (!if_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("redir_valid", {31'b0, if_valid}, 32'h1);
        chk("redir_pc",    if_pc,    32'h100);
        chk("redir_instr", if_instr, 32'h0004_0013);

        // Redirect coinciding with rvalid for 0x104.
        step();
        chk("rv_present", {31'b0, rvalid}, 32'h1);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("rv_redir_valid", {31'b0, if_valid}, 32'h0);
        chk("rv_redir_req",   {31'b0, req}, 32'h1);
        chk("rv_redir_addr",  addr, 32'h200);

        // Redirect in REQ with no grant changes the address at once.
        gnt_en = 1'b0;
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0301;
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("nogrant_addr", addr, 32'h300);
        chk("nogrant_req",  {31'b0, req}, 32'h1);

        // Back-to-back redirects while a killed fetch is outstanding.
        gnt_en = 1'b1; lat = 4;
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0400;
        step(); redirect_pc = 32'h0000_0500;
        step(); redirect = 1'b0; lat = 1;
        n = 0;
        @(negedge clk);
        while (!req && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("multi_addr", addr, 32'h500);

        // Mixed stall / latency traffic under the model.
        for (int i = 0; i < 30; i++) begin
            stall = (i % 3 == 1);
            lat   = 1 + (i % 4 == 2 ? 2 : 0);
            step();
        end
        stall = 1'b0;
        repeat (8) step();

        // Wrapping reset PC on the second instance.
        rst2 = 1'b0;
        @(negedge clk);
        chk("w_c0_req",  {31'b0, req2}, 32'h0);
        chk("w_c0_addr", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_c1_req",  {31'b0, req2}, 32'h1);
        chk("w_c1_addr", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("w_c2_req",  {31'b0, req2}, 32'h0);
        @(negedge clk);
        chk("w_c3_valid", {31'b0, valid2}, 32'h1);
        chk("w_c3_pc",    pc2,    32'hFFFF_FFFC);
        chk("w_c3_instr", instr2, 32'hFFFF_F013);
        chk("w_c3_req",   {31'b0, req2}, 32'h1);
        chk("w_c3_addr",  addr2,  32'h0);
        step(); rst2 = 1'b1;
        @(negedge clk);
        chk("w_c4_req", {31'b0, req2}, 32'h0);
        step();
        @(negedge clk);
        chk("w_rst_req",   {31'b0, req2},   32'h0);
        chk("w_rst_addr",  addr2,           32'hFFFF_FFFC);
        chk("w_rst_valid", {31'b0, valid2}, 32'h0);
        chk("w_rst_instr", instr2,          32'h0000_0013);
        chk("w_rst_pc",    pc2,             32'h0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RISC-V pipeline front end. It owns the program counter and drives a handshaked instruction-memory port with one request outstanding at a time. It handles branch and jump redirects from EX, and downstream stalls from the hazard logic, and it presents each fetched instruction and its PC in a registered output slot that feeds the IF/ID boundary.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall_i  in  1  ID cannot accept the output slot this cycle.
- redirect_i  in  1  EX redirect (taken branch or jump); single-cycle pulse.
- redirect_pc_i  in  32  redirect target (EX ALU result); bits [1:0] are ignored and treated as 0.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (current PC).
- imem_gnt_i  in  1  memory accepted the request this cycle.
- imem_rvalid_i  in  1  response valid; earliest arrival is one cycle after the grant.
- imem_rdata_i  in  32  response instruction.
- if_valid_o  out  1  output slot holds a valid instruction.
- if_instr_o  out  32  instruction in the output slot.
- if_pc_o  out  32  PC of `if_instr_o`.

## Operation
- Registers: `state`, `pc`, `kill`, and the output slot (`out_valid`, `out_instr`, `out_pc`).
- States:
  - FS_RESET: held while `rst` is high; leaves to FS_REQ on the first cycle after `rst` deasserts.
  - FS_REQ:
    - `imem_req_o` = `!out_valid || !stall_i`, so a response always lands in a free slot.
    - `imem_addr_o` = `pc`.
    - Moves to FS_WAIT when `imem_req_o` and `imem_gnt_i` are both high.
  - FS_WAIT:
    - `imem_req_o` = 0.
    - On `imem_rvalid_i`, moves to FS_REQ.
    - If `kill` is 0: load the slot with `out_valid`=1, `out_instr`=`imem_rdata_i`, `out_pc`=`pc`, and set `pc`=`pc`+4.
    - If `kill` is 1: discard the response and clear `kill`.
- Slot consumption: a slot is consumed on any cycle with `out_valid` high and `stall_i` low. `out_valid` clears on that edge unless a new response loads it on the same edge.
- Redirect (`redirect_i`) has highest priority and takes effect on the same edge:
  - `pc` = `{redirect_pc_i[31:2],2'b00}`.
  - `out_valid` = 0.
  - In FS_REQ with no grant: no other effect. An ungranted address is allowed to change.
  - In FS_REQ with a grant, or in FS_WAIT without `rvalid`: set `kill`=1 and go to or stay in FS_WAIT.
  - In FS_WAIT with `rvalid`: discard the response, `kill`=0, go to FS_REQ.
  - Repeated redirects while `kill` is 1: the latest target wins.
- Stall: holds the slot contents unchanged and never drops an in-flight response.
- PC arithmetic: 32-bit, wrapping modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset values:
  - `state`=FS_RESET, `pc`=RESET_PC, `kill`=0.
  - `imem_req_o`=0, `imem_addr_o`=RESET_PC.
  - `if_valid_o`=0, `if_instr_o`=32'h0000_0013 (NOP), `if_pc_o`=0.
- Reset mid-transaction: any outstanding response after reset is not tracked. The memory must also be reset by `rst`.

## Timing
- All outputs are registered except `imem_req_o`, which depends combinationally on `stall_i`.
- Minimum fetch latency: grant in cycle N, `rvalid` in N+1, `if_valid_o` high in N+2.
- Peak throughput: one instruction per 2 cycles (REQ→WAIT→REQ).
- Redirect seen at edge E: the first address at the new target is presented in cycle E+1 if the FSM is in FS_REQ. Otherwise it is presented the cycle after the killed response returns.
- No combinational path from `imem_rdata_i` or `redirect_pc_i` to any output.

## Structure
- Shared package `riscv_pkg`:
  - enum `fetch_state_t` {FS_RESET, FS_REQ, FS_WAIT}.
  - `NOP_INSTR`=32'h0000_0013.
  - `PC_INC`=4.
- One sub-module, `fetch_pc_next`: combinational next-PC mux. Priority order: redirect, then PC+4 on accepted response, then hold. It outputs the aligned target.
- All remaining logic is one FSM plus slot registers in `fetch_ctrl`.

## Test plan
- Reset, then a memory with 1-cycle latency returning 0x00500093, 0x00A00113 → `imem_addr_o` shows 0x0, then 0x4. `if_valid_o` rises at cycle 3 with `if_pc_o`=0x0, `if_instr_o`=0x00500093. Next slot: pc 0x4, instr 0x00A00113.
- Hold `stall_i`=1 with a valid slot (pc 0x4) for 5 cycles → slot unchanged and `imem_req_o`=0 throughout. Release → slot consumed and a request for 0x8 is issued in the same cycle.
- Grant for 0x8, then `redirect_i` with `redirect_pc_i`=0x103 while in FS_WAIT, response arrives 3 cycles later → response discarded, `if_valid_o` stays 0. The next request is 0x100 and its response appears with `if_pc_o`=0x100.
- `redirect_i` with `redirect_pc_i`=0x200 in the same cycle as `rvalid` and with a valid slot → slot cleared, response discarded, next `imem_addr_o`=0x200.
- `RESET_PC`=32'hFFFF_FFFC: fetch two instructions → second `imem_addr_o`=0x0. Assert `rst` while in FS_WAIT → all outputs return to their reset values on the next edge.
